neuron_reduce_act: RTL and testbench

- Downstream stage of the neuron outer-product array.
- Consumes the IDIM x ODIM product grid that the array emits on its STREAM_O bus. Reduces each output column over the IDIM rows, adds a per-column bias, saturates to DWIDTH and applies an optional ReLU.
- Result is one DWIDTH word per output neuron, ready for the next layer's STREAM_A input.
- Reduction is serial over rows, one row per clock; all ODIM columns are processed in parallel.

---
 rtl/neuron_reduce_act.sv | 111 +++++++++++
 tb/tb_neuron_reduce_act.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/neuron_reduce_act.sv
// Column-parallel, row-serial reduction of a product grid, followed by bias add,
// signed saturation to DWIDTH and optional ReLU.
module neuron_reduce_act #(
  parameter int DWIDTH = 32,
  parameter int IDIM   = 1,
  parameter int ODIM   = 2,
  parameter int RELU   = 1,
  parameter int ISIZE  = DWIDTH*IDIM*ODIM,
  parameter int OSIZE  = DWIDTH*ODIM,
  parameter int AWIDTH = DWIDTH+$clog2(IDIM+1)+1
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ISIZE-1:0]  STREAM_I,
  input  logic [OSIZE-1:0]  BIAS,
  output logic              BUSY,
  output logic              DONE,
  output logic [OSIZE-1:0]  STREAM_O
);

  localparam int RWIDTH = (IDIM > 1) ? $clog2(IDIM) : 1;
  localparam logic [RWIDTH-1:0] LAST_ROW = RWIDTH'(IDIM-1);
  localparam logic [AWIDTH-1:0] SAT_MAX  = {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic [AWIDTH-1:0] SAT_MIN  = {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_t;

  state_t             state, state_nxt;
  logic [RWIDTH-1:0]  row;
  logic [ISIZE-1:0]   grid_q;
  logic [OSIZE-1:0]   bias_q;
  logic [AWIDTH-1:0]  acc [ODIM];
  logic [AWIDTH-1:0]  sum [ODIM];
  logic [OSIZE-1:0]   row_data;
  logic [OSIZE-1:0]   addend;
  logic [OSIZE-1:0]   result;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_ACCUM;
      S_ACCUM: if (row == LAST_ROW) state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign BUSY = (state == S_ACCUM) || (state == S_BIAS);
  assign DONE = (state == S_OUT);

  // One shared adder per column: grid row during ACCUM, bias during BIAS.
  always_comb begin
    row_data = grid_q[OSIZE-1:0];
    for (int r = 0; r < IDIM; r++) begin
      if (row == RWIDTH'(r)) row_data = grid_q[r*OSIZE +: OSIZE];
    end
    addend = (state == S_BIAS) ? bias_q : row_data;
  end

  always_comb begin
    result = '0;
    for (int c = 0; c < ODIM; c++) begin
      sum[c] = acc[c] + {{(AWIDTH-DWIDTH){addend[c*DWIDTH+DWIDTH-1]}}, addend[c*DWIDTH +: DWIDTH]};
      if ($signed(sum[c]) > $signed(SAT_MAX))
        result[c*DWIDTH +: DWIDTH] = {1'b0, {(DWIDTH-1){1'b1}}};
      else if ($signed(sum[c]) < $signed(SAT_MIN))
        result[c*DWIDTH +: DWIDTH] = {1'b1, {(DWIDTH-1){1'b0}}};
      else
        result[c*DWIDTH +: DWIDTH] = sum[c][DWIDTH-1:0];
      if (RELU != 0 && sum[c][AWIDTH-1])
        result[c*DWIDTH +: DWIDTH] = '0;
    end
  end

  // The result is registered on the BIAS->OUT edge so STREAM_O is valid with DONE.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      row      <= '0;
      grid_q   <= '0;
      bias_q   <= '0;
      STREAM_O <= '0;
      for (int c = 0; c < ODIM; c++) acc[c] <= '0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          grid_q <= STREAM_I;
          bias_q <= BIAS;
          row    <= '0;
          for (int c = 0; c < ODIM; c++) acc[c] <= '0;
        end
        S_ACCUM: begin
          for (int c = 0; c < ODIM; c++) acc[c] <= sum[c];
          row <= row + 1'b1;
        end
        S_BIAS: begin
          for (int c = 0; c < ODIM; c++) acc[c] <= sum[c];
          STREAM_O <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_reduce_act.sv
// Directed bench for neuron_reduce_act: three instances cover IDIM=2 (RELU off/on)
// and IDIM=1 with three columns.
module tb_neuron_reduce_act;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [127:0] g0 = '0, g1 = '0;
  logic [95:0]  g2 = '0;
  logic [63:0]  b0 = '0, b1 = '0;
  logic [95:0]  b2 = '0;
  logic         busy0, busy1, busy2, done0, done1, done2;
  logic [63:0]  o0, o1;
  logic [95:0]  o2;

  int n_checks = 0;
  int n_fail = 0;

  neuron_reduce_act #(.DWIDTH(32), .IDIM(2), .ODIM(2), .RELU(0)) u0 (
    .CLOCK(clk), .RESET_N(rst_n), .START(s0), .STREAM_I(g0), .BIAS(b0),
    .BUSY(busy0), .DONE(done0), .STREAM_O(o0));

  neuron_reduce_act #(.DWIDTH(32), .IDIM(2), .ODIM(2), .RELU(1)) u1 (
    .CLOCK(clk), .RESET_N(rst_n), .START(s1), .STREAM_I(g1), .BIAS(b1),
    .BUSY(busy1), .DONE(done1), .STREAM_O(o1));

  neuron_reduce_act #(.DWIDTH(32), .IDIM(1), .ODIM(3), .RELU(1)) u2 (
    .CLOCK(clk), .RESET_N(rst_n), .START(s2), .STREAM_I(g2), .BIAS(b2),
    .BUSY(busy2), .DONE(done2), .STREAM_O(o2));

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one op on u0 (which=0) or u1 (which=1) for 12 cycles; START is cycle 0.
  // Optionally re-asserts START with grid g_hz during cycle hz_cyc (0 disables).
  task automatic run22(input int which, input logic [127:0] g, input logic [63:0] b,
                       input int hz_cyc, input logic [127:0] g_hz,
                       output int done_at, output int n_done, output int busy_err,
                       output logic [63:0] res);
    logic bz, dn;
    done_at = -1; n_done = 0; busy_err = 0; res = '0;
    @(negedge clk);
    if (which == 0) begin s0 = 1'b1; g0 = g; b0 = b; end
    else            begin s1 = 1'b1; g1 = g; b1 = b; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (which == 0) begin s0 = 1'b0; bz = busy0; dn = done0; end
      else            begin s1 = 1'b0; bz = busy1; dn = done1; end
      if (k == hz_cyc) begin
        if (which == 0) begin s0 = 1'b1; g0 = g_hz; end
        else            begin s1 = 1'b1; g1 = g_hz; end
      end
      if (bz !== (k >= 1 && k <= 3)) busy_err++;
      if (dn === 1'b1) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k;
          res = (which == 0) ? o0 : o1;
        end
      end
    end
  endtask

  localparam logic [127:0] GRID_BASIC = {32'hFFFFFFFE, 32'd7, 32'd5, 32'd3};
  localparam logic [63:0]  BIAS_BASIC = {32'd10, 32'd1};
  localparam logic [63:0]  RES_BASIC  = {32'd13, 32'd11};
  localparam logic [127:0] GRID_ONES  = {32'd1, 32'd1, 32'd1, 32'd1};

  initial begin
    int dat, nd, be, k;
    logic [63:0] r;
    logic seen;

    repeat (3) @(negedge clk);
    check_value("reset_out0", o0, 0);
    check_value("reset_busy0", busy0, 0);
    check_value("reset_done0", done0, 0);
    check_value("reset_out2", o2, 0);
    rst_n = 1'b1;

    run22(0, GRID_BASIC, BIAS_BASIC, 0, '0, dat, nd, be, r);
    check_value("basic_done_cycle", dat, 4);
    check_value("basic_n_done", nd, 1);
    check_value("basic_busy", be, 0);
    check_value("basic_result", r, RES_BASIC);
    check_value("basic_hold", o0, RES_BASIC);

    run22(1, {32'd1, 32'd1, 32'd2, 32'hFFFFFFFC}, {32'hFFFFFFFB, 32'd0}, 0, '0, dat, nd, be, r);
    check_value("relu_neg_done", dat, 4);
    check_value("relu_neg_result", r, 64'd0);
    run22(1, {32'd1, 32'd1, 32'd2, 32'hFFFFFFFC}, {32'd5, 32'd10}, 0, '0, dat, nd, be, r);
    check_value("relu_pos_result", r, {32'd8, 32'd7});
    check_value("relu_pos_busy", be, 0);

    run22(0, {4{32'h7FFFFFFF}}, {2{32'h7FFFFFFF}}, 0, '0, dat, nd, be, r);
    check_value("sat_max", r, {2{32'h7FFFFFFF}});
    run22(0, {4{32'h80000000}}, {2{32'h80000000}}, 0, '0, dat, nd, be, r);
    check_value("sat_min", r, {2{32'h80000000}});

    run22(0, GRID_BASIC, BIAS_BASIC, 2, GRID_ONES, dat, nd, be, r);
    check_value("hz_busy_done_cycle", dat, 4);
    check_value("hz_busy_n_done", nd, 1);
    check_value("hz_busy_result", r, RES_BASIC);

    // START coinciding with DONE is ignored; held one more cycle it is accepted.
    @(negedge clk);
    s0 = 1'b1; g0 = GRID_BASIC; b0 = BIAS_BASIC;
    @(negedge clk);
    s0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    check_value("hz_done_seen", seen, 1);
    s0 = 1'b1; g0 = GRID_ONES; b0 = '0;
    @(negedge clk);
    check_value("hz_done_ignored_busy", busy0, 0);
    check_value("hz_done_ignored_done", done0, 0);
    @(negedge clk);
    s0 = 1'b0;
    check_value("hz_next_busy", busy0, 1);
    k = 1; seen = 1'b0;
    while (k < 10 && !seen) begin
      @(negedge clk);
      k++;
      if (done0 === 1'b1) seen = 1'b1;
    end
    check_value("hz_next_latency", seen ? k : -1, 4);
    check_value("hz_next_result", o0, {32'd2, 32'd2});

    // Reset mid-operation.
    @(negedge clk);
    s0 = 1'b1; g0 = GRID_BASIC; b0 = BIAS_BASIC;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("rst_mid_out", o0, 0);
    check_value("rst_mid_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) nd++;
    end
    check_value("rst_mid_no_done", nd, 0);
    run22(0, GRID_BASIC, BIAS_BASIC, 0, '0, dat, nd, be, r);
    check_value("rst_recover_result", r, RES_BASIC);

    // IDIM=1, ODIM=3; inputs change after the START cycle.
    @(negedge clk);
    s2 = 1'b1; g2 = {32'd3, 32'd2, 32'd1}; b2 = '0;
    dat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin s2 = 1'b0; g2 = {3{32'd9}}; b2 = {3{32'd5}}; end
      if (done2 === 1'b1 && dat < 0) begin
        dat = i;
        check_value("idim1_result", o2, {32'd3, 32'd2, 32'd1});
      end
    end
    check_value("idim1_done_cycle", dat, 3);
    check_value("idim1_hold", o2, {32'd3, 32'd2, 32'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
